// File: rtl/id_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage register scoreboard.
// The register address width and variable-latency code fall back to
// their ncpu64k defaults when no configuration header has set them.
`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif
`ifndef SB_LAT_VAR
`define SB_LAT_VAR 0
`endif

package id_scoreboard_pkg;

  localparam int unsigned REG_AW   = `NCPU_REG_AW;
  localparam int unsigned NREG     = 1 << REG_AW;
  localparam int unsigned SB_LAT_VAR_C = `SB_LAT_VAR;

  localparam int unsigned DEF_P_ISSUE_WIDTH = 1;
  localparam int unsigned DEF_WB_PORTS      = 2;
  localparam int unsigned DEF_LAT_W         = 3;

  // Count of set bits; the grant vector is a prefix mask, so this is the issue count
  function automatic int unsigned clo_popcnt(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int k = 0; k < 32; k++) n += 32'(v[k]);
    return n;
  endfunction

endpackage

// File: rtl/id_sb_if.sv
// Decoder/writeback-side bundle for the scoreboard: issue window, flush/stall,
// writeback releases and the grant/busy results.
interface id_sb_if #(
  parameter int unsigned P_ISSUE_WIDTH = 1,
  parameter int unsigned WB_PORTS      = 2,
  parameter int unsigned LAT_W         = 3
);
  import id_scoreboard_pkg::*;

  localparam int unsigned IW = 1 << P_ISSUE_WIDTH;

  logic                       flush;
  logic                       stall;
  logic [IW-1:0]              req_valid;
  logic [IW-1:0]              req_rs1_re;
  logic [IW-1:0]              req_rs2_re;
  logic [IW*REG_AW-1:0]       req_rs1_addr;
  logic [IW*REG_AW-1:0]       req_rs2_addr;
  logic [IW-1:0]              req_rd_we;
  logic [IW*REG_AW-1:0]       req_rd_addr;
  logic [IW*LAT_W-1:0]        req_rd_lat;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*REG_AW-1:0] wb_addr;
  logic [IW-1:0]              issue_grant;
  logic [P_ISSUE_WIDTH:0]     issue_cnt;
  logic [NREG-1:0]            sb_busy;

  modport master (
    output flush, stall, req_valid, req_rs1_re, req_rs2_re, req_rs1_addr,
           req_rs2_addr, req_rd_we, req_rd_addr, req_rd_lat, wb_valid, wb_addr,
    input  issue_grant, issue_cnt, sb_busy
  );

  modport slave (
    input  flush, stall, req_valid, req_rs1_re, req_rs2_re, req_rs1_addr,
           req_rs2_addr, req_rd_we, req_rd_addr, req_rd_lat, wb_valid, wb_addr,
    output issue_grant, issue_cnt, sb_busy
  );
endinterface

// File: rtl/id_sb_entry.sv
// One scoreboard entry: busy/var/countdown state for a single register.
module id_sb_entry
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             set_i,
  input  logic [LAT_W-1:0] set_lat_i,
  input  logic             rel_i,
  output logic             busy_o
);

  logic             busy_q, busy_d;
  logic             var_q, var_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Next state: a new set overrides any release; variable owners ignore flush
  always_comb begin
    busy_d = busy_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    if (set_i) begin
      if (set_lat_i == LAT_W'(SB_LAT_VAR_C)) begin
        busy_d = 1'b1;
        var_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        busy_d = (set_lat_i > LAT_W'(1));
        var_d  = 1'b0;
        cnt_d  = set_lat_i - LAT_W'(1);
      end
    end else if (var_q && busy_q) begin
      if (rel_i) begin
        busy_d = 1'b0;
        var_d  = 1'b0;
      end
    end else if (flush_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (cnt_q <= LAT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q - LAT_W'(1);
      end
    end
  end

  // Entry state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      var_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      var_q  <= var_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard and in-order prefix issue grant.
// Optional: define NCPU_SB_PERF_EN to add perf_sb_stall_cnt, a 32-bit count
// of cycles where slot 0 was ready to go but held by a hazard.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned CONFIG_P_ISSUE_WIDTH = DEF_P_ISSUE_WIDTH,
  parameter int unsigned CONFIG_WB_PORTS      = DEF_WB_PORTS,
  parameter int unsigned CONFIG_LAT_W         = DEF_LAT_W
) (
  input  logic        clk,
  input  logic        rst,
  id_sb_if.slave      sb
`ifdef NCPU_SB_PERF_EN
  ,
  output logic [31:0] perf_sb_stall_cnt
`endif
);

  localparam int unsigned IW    = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int unsigned WBP   = CONFIG_WB_PORTS;
  localparam int unsigned LW    = CONFIG_LAT_W;
  localparam int unsigned CNT_W = CONFIG_P_ISSUE_WIDTH + 1;

  logic [NREG-1:0]   busy;
  logic [IW-1:0]     hazard;
  logic [IW-1:0]     grant;
  logic [REG_AW-1:0] rs1 [IW];
  logic [REG_AW-1:0] rs2 [IW];
  logic [REG_AW-1:0] rd  [IW];
  logic [LW-1:0]     lat [IW];
  logic [NREG-1:1]   set_vec;
  logic [NREG-1:1]   rel_vec;
  logic [LW-1:0]     set_lat [1:NREG-1];

  // Unpack the flat slot fields
  always_comb begin
    for (int i = 0; i < IW; i++) begin
      rs1[i] = sb.req_rs1_addr[i*REG_AW +: REG_AW];
      rs2[i] = sb.req_rs2_addr[i*REG_AW +: REG_AW];
      rd[i]  = sb.req_rd_addr[i*REG_AW +: REG_AW];
      lat[i] = sb.req_rd_lat[i*LW +: LW];
    end
  end

  // RAW/WAW hazards against the scoreboard and older slots in the window
  always_comb begin
    hazard = '0;
    for (int i = 0; i < IW; i++) begin
      if ((sb.req_rs1_re[i] && busy[rs1[i]]) ||
          (sb.req_rs2_re[i] && busy[rs2[i]]) ||
          (sb.req_rd_we[i]  && busy[rd[i]]))
        hazard[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (sb.req_rd_we[j] && (rd[j] != '0) &&
            ((sb.req_rs1_re[i] && (rs1[i] == rd[j])) ||
             (sb.req_rs2_re[i] && (rs2[i] == rd[j])) ||
             (sb.req_rd_we[i]  && (rd[i]  == rd[j]))))
          hazard[i] = 1'b1;
      end
    end
  end

  // In-order prefix grant
  always_comb begin
    grant    = '0;
    grant[0] = sb.req_valid[0] & ~hazard[0] & ~sb.stall & ~sb.flush;
    for (int i = 1; i < IW; i++)
      grant[i] = grant[i-1] & sb.req_valid[i] & ~hazard[i];
  end

  // Per-register set (from granted writers) and release (from writeback ports)
  always_comb begin
    set_vec = '0;
    rel_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      set_lat[r] = '0;
      for (int i = 0; i < IW; i++) begin
        if (grant[i] && sb.req_rd_we[i] && (rd[i] == REG_AW'(r))) begin
          set_vec[r] = 1'b1;
          set_lat[r] = lat[i];
        end
      end
      for (int p = 0; p < WBP; p++) begin
        if (sb.wb_valid[p] && (sb.wb_addr[p*REG_AW +: REG_AW] == REG_AW'(r)))
          rel_vec[r] = 1'b1;
      end
    end
  end

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    id_sb_entry #(.LAT_W(LW)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (sb.flush),
      .set_i     (set_vec[r]),
      .set_lat_i (set_lat[r]),
      .rel_i     (rel_vec[r]),
      .busy_o    (busy[r])
    );
  end

  assign sb.issue_grant = grant;
  assign sb.issue_cnt   = CNT_W'(clo_popcnt(32'(grant)));
  assign sb.sb_busy     = busy;

`ifdef NCPU_SB_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Count hazard-blocked cycles of the oldest slot
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (sb.req_valid[0] && !sb.stall && !sb.flush && hazard[0])
      perf_cnt_d = perf_cnt_q + 32'd1;
  end

  // Perf counter register
  always_ff @(posedge clk) begin
    if (rst) perf_cnt_q <= '0;
    else     perf_cnt_q <= perf_cnt_d;
  end

  assign perf_sb_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios followed by random traffic,
// checked each cycle against a ready-cycle reference model.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int unsigned P   = 1;
  localparam int unsigned IW  = 2;
  localparam int unsigned WBP = 2;
  localparam int unsigned LW  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_sb_if #(.P_ISSUE_WIDTH(P), .WB_PORTS(WBP), .LAT_W(LW)) sb ();
`ifdef NCPU_SB_PERF_EN
  logic [31:0] perf;
`endif

  id_scoreboard #(
    .CONFIG_P_ISSUE_WIDTH(P), .CONFIG_WB_PORTS(WBP), .CONFIG_LAT_W(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
`ifdef NCPU_SB_PERF_EN
    , .perf_sb_stall_cnt(perf)
`endif
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // Model: variable owners pending writeback, fixed owners busy until m_ready
  bit          m_var   [NREG];
  int          m_ready [NREG];
  int unsigned m_perf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (m_var[r] || (cyc < m_ready[r]));
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREG; r++) begin
      m_var[r]   = 1'b0;
      m_ready[r] = 0;
    end
    m_perf = 0;
  endtask

  task automatic model_grant(output logic [IW-1:0] g, output bit haz0);
    bit ok;
    ok   = !sb.stall && !sb.flush;
    g    = '0;
    haz0 = 1'b0;
    for (int i = 0; i < IW; i++) begin
      int r1, r2, rdi;
      bit e1, e2, we, h;
      r1  = int'(sb.req_rs1_addr[i*REG_AW +: REG_AW]);
      r2  = int'(sb.req_rs2_addr[i*REG_AW +: REG_AW]);
      rdi = int'(sb.req_rd_addr[i*REG_AW +: REG_AW]);
      e1  = sb.req_rs1_re[i];
      e2  = sb.req_rs2_re[i];
      we  = sb.req_rd_we[i];
      h   = (e1 && m_busy(r1)) || (e2 && m_busy(r2)) || (we && m_busy(rdi));
      for (int j = 0; j < i; j++) begin
        int rdj;
        rdj = int'(sb.req_rd_addr[j*REG_AW +: REG_AW]);
        if (sb.req_rd_we[j] && rdj != 0 &&
            ((e1 && r1 == rdj) || (e2 && r2 == rdj) || (we && rdi == rdj)))
          h = 1'b1;
      end
      if (i == 0) haz0 = h;
      ok   = ok && sb.req_valid[i] && !h;
      g[i] = ok;
    end
  endtask

  // Compare outputs against the model, advance the model across the edge
  task automatic step(input string tag);
    logic [IW-1:0]   g;
    logic [NREG-1:0] eb;
    bit              h0;
    #1;
    model_grant(g, h0);
    for (int r = 0; r < NREG; r++) eb[r] = m_busy(r);
    chk({tag, ".grant"}, 64'(sb.issue_grant), 64'(g));
    chk({tag, ".cnt"},   64'(sb.issue_cnt),   64'($countones(g)));
    chk({tag, ".busy"},  64'(sb.sb_busy),     64'(eb));
`ifdef NCPU_SB_PERF_EN
    chk({tag, ".perf"},  64'(perf),           64'(m_perf));
`endif
    if (rst) begin
      m_clear();
    end else begin
      if (!sb.stall && !sb.flush && sb.req_valid[0] && h0) m_perf++;
      if (sb.flush)
        for (int r = 0; r < NREG; r++)
          if (m_ready[r] > cyc + 1) m_ready[r] = cyc + 1;
      for (int p = 0; p < WBP; p++)
        if (sb.wb_valid[p]) m_var[int'(sb.wb_addr[p*REG_AW +: REG_AW])] = 1'b0;
      for (int i = 0; i < IW; i++) begin
        int rdi, l;
        rdi = int'(sb.req_rd_addr[i*REG_AW +: REG_AW]);
        l   = int'(sb.req_rd_lat[i*LW +: LW]);
        if (g[i] && sb.req_rd_we[i] && rdi != 0) begin
          if (l == 0) begin
            m_var[rdi]   = 1'b1;
            m_ready[rdi] = 0;
          end else begin
            m_var[rdi]   = 1'b0;
            m_ready[rdi] = cyc + l;
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    sb.flush        = 1'b0;
    sb.stall        = 1'b0;
    sb.req_valid    = '0;
    sb.req_rs1_re   = '0;
    sb.req_rs2_re   = '0;
    sb.req_rs1_addr = '0;
    sb.req_rs2_addr = '0;
    sb.req_rd_we    = '0;
    sb.req_rd_addr  = '0;
    sb.req_rd_lat   = '0;
    sb.wb_valid     = '0;
    sb.wb_addr      = '0;
  endtask

  task automatic slot(input int i, input bit e1, input int r1, input bit e2, input int r2,
                      input bit we, input int rdi, input int l);
    sb.req_valid[i]                     = 1'b1;
    sb.req_rs1_re[i]                    = e1;
    sb.req_rs2_re[i]                    = e2;
    sb.req_rd_we[i]                     = we;
    sb.req_rs1_addr[i*REG_AW +: REG_AW] = REG_AW'(r1);
    sb.req_rs2_addr[i*REG_AW +: REG_AW] = REG_AW'(r2);
    sb.req_rd_addr[i*REG_AW +: REG_AW]  = REG_AW'(rdi);
    sb.req_rd_lat[i*LW +: LW]           = LW'(l);
  endtask

  task automatic wb(input int p, input int a);
    sb.wb_valid[p]                 = 1'b1;
    sb.wb_addr[p*REG_AW +: REG_AW] = REG_AW'(a);
  endtask

  initial begin
    m_clear();
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step("reset");
    rst = 1'b0;

    // add r3 (L=1) with independent sub r4 <- r5: both issue
    clr(); slot(0, 0, 0, 0, 0, 1, 3, 1); slot(1, 1, 5, 0, 0, 1, 4, 1);
    #1 chk("t1.grant_c", 64'(sb.issue_grant), 64'(2'b11));
    chk("t1.cnt_c", 64'(sb.issue_cnt), 64'd2);
    step("t1");
    clr(); #1 chk("t1.busy_c", 64'(sb.sb_busy), 64'd0); step("t1b");

    // mul r6 (L=3) with same-window reader, then reader alone
    clr(); slot(0, 0, 0, 0, 0, 1, 6, 3); slot(1, 1, 6, 0, 0, 1, 11, 1);
    #1 chk("t2.win_c", 64'(sb.issue_grant), 64'(2'b01)); step("t2");
    for (int k = 0; k < 2; k++) begin
      clr(); slot(0, 1, 6, 0, 0, 1, 11, 1);
      #1 chk("t2.blk_c", 64'(sb.issue_grant), 64'd0);
      chk("t2.busy6_c", 64'(sb.sb_busy[6]), 64'd1);
      step("t2b");
    end
    clr(); slot(0, 1, 6, 0, 0, 1, 11, 1);
    #1 chk("t2.go_c", 64'(sb.issue_grant), 64'(2'b01));
    chk("t2.free6_c", 64'(sb.sb_busy[6]), 64'd0);
    step("t2c");

    // load r7 (variable) blocks its reader until writeback
    clr(); slot(0, 0, 0, 0, 0, 1, 7, 0); step("t3.ld");
    for (int k = 0; k < 4; k++) begin
      clr(); slot(0, 1, 7, 0, 0, 1, 12, 1);
      #1 chk("t3.blk_c", 64'(sb.issue_grant), 64'd0);
      step("t3.blk");
    end
    clr(); slot(0, 1, 7, 0, 0, 1, 12, 1); wb(1, 7);
    #1 chk("t3.wbcyc_c", 64'(sb.issue_grant), 64'd0); step("t3.wb");
    clr(); slot(0, 1, 7, 0, 0, 1, 12, 1);
    #1 chk("t3.go_c", 64'(sb.issue_grant), 64'(2'b01)); step("t3.go");

    // flush drops fixed owners, keeps variable ones
    clr(); slot(0, 0, 0, 0, 0, 1, 8, 0); step("t4.ld");
    clr(); slot(0, 0, 0, 0, 0, 1, 9, 4); step("t4.mul");
    clr(); sb.flush = 1'b1; slot(0, 0, 0, 0, 0, 1, 13, 1);
    #1 chk("t4.flgrant_c", 64'(sb.issue_grant), 64'd0);
    chk("t4.busy9_c", 64'(sb.sb_busy[9]), 64'd1);
    step("t4.fl");
    clr();
    #1 chk("t4.clr9_c", 64'(sb.sb_busy[9]), 64'd0);
    chk("t4.keep8_c", 64'(sb.sb_busy[8]), 64'd1);
    step("t4.after");
    repeat (3) step("t4.wait");
    clr(); wb(0, 8); step("t4.wb");
    clr(); #1 chk("t4.rel8_c", 64'(sb.sb_busy[8]), 64'd0); step("t4.done");

    // release and set of r10 in the same cycle: set wins
    clr(); wb(0, 10); slot(0, 0, 0, 0, 0, 1, 10, 0);
    #1 chk("t5.grant_c", 64'(sb.issue_grant), 64'(2'b01)); step("t5");
    clr(); #1 chk("t5.busy10_c", 64'(sb.sb_busy[10]), 64'd1); step("t5b");
    step("t5c");
    clr(); wb(1, 10); step("t5.wb");
    clr(); #1 chk("t5.rel10_c", 64'(sb.sb_busy[10]), 64'd0); step("t5d");

    // r0 writer and reader: never a hazard
    clr(); slot(0, 0, 0, 0, 0, 1, 0, 2); slot(1, 1, 0, 1, 0, 1, 14, 1);
    #1 chk("t6.grant_c", 64'(sb.issue_grant), 64'(2'b11)); step("t6");
    clr(); #1 chk("t6.busy0_c", 64'(sb.sb_busy[0]), 64'd0); step("t6b");

    // stall suppresses grants
    clr(); sb.stall = 1'b1; slot(0, 0, 0, 0, 0, 1, 15, 1);
    #1 chk("t7.stall_c", 64'(sb.issue_grant), 64'd0); step("t7");

    // random traffic on a small register pool to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      clr();
      rst      = ($urandom_range(0, 249) == 0);
      sb.flush = ($urandom_range(0, 15) == 0);
      sb.stall = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < IW; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          bit we;
          we = 1'($urandom_range(0, 1));
          slot(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  we, we ? int'($urandom_range(0, 7)) : 0, int'($urandom_range(0, 7)));
        end
      end
      for (int p = 0; p < WBP; p++)
        if ($urandom_range(0, 2) == 0) wb(p, int'($urandom_range(0, 7)));
      step("rnd");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Register scoreboard and issue-grant controller for the multi-issue ID stage.
- Tracks in-flight destination registers: fixed-latency writers (ALU/MUL) use countdowns; variable-latency writers (LSU/DIV) are released by writeback ports.
- Each cycle it grants the longest in-order prefix of the issue window that is free of RAW/WAW hazards against the scoreboard and against older slots in the same window.
- Sits between the decoder outputs and the ARF read / EX dispatch.

Parameters:
- CONFIG_P_ISSUE_WIDTH, 1, log2 of issue slots (IW=1<<P).
- CONFIG_WB_PORTS, 2, number of variable-latency writeback release ports.
- CONFIG_LAT_W, 3, width of the latency field and countdown counters.
- Register address width is `NCPU_REG_AW (5) from ncpu64k_config.vh; NREG = 1<<`NCPU_REG_AW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush
- stall  in  1  downstream stall; no grants while high
- req_valid  in  IW  slot i holds a decoded instruction
- req_rs1_re / req_rs2_re  in  IW  source-read enables
- req_rs1_addr / req_rs2_addr  in  IW*`NCPU_REG_AW  source addresses
- req_rd_we  in  IW  destination-write enable
- req_rd_addr  in  IW*`NCPU_REG_AW  destination address
- req_rd_lat  in  IW*CONFIG_LAT_W  0 = variable latency, L>=1 = fixed latency
- wb_valid  in  CONFIG_WB_PORTS  variable-latency writeback occurred
- wb_addr  in  CONFIG_WB_PORTS*`NCPU_REG_AW  written register
- issue_grant  out  IW  granted slots (prefix mask)
- issue_cnt  out  CONFIG_P_ISSUE_WIDTH+1  popcount of issue_grant
- sb_busy  out  NREG  current busy vector (debug/verification)

Behaviour:
- State per register r: busy[r], var[r] (variable-latency owner), cnt[r] (CONFIG_LAT_W bits).
- Reset (rst=1 at a clk edge): all busy/var/cnt cleared.
- Outputs are combinational from state and inputs: issue_grant=0, issue_cnt=0, sb_busy=0 while state is cleared and no req_valid is set.
- Register 0 is never marked busy and never creates a hazard (hardwired zero).
- Slot i hazard if any of the following holds:
  - (rs1_re & busy[rs1]) or (rs2_re & busy[rs2]);
  - rd_we & busy[rd] (WAW);
  - some j<i with rd_we[j], rd[j]!=0, and rd[j] matching slot i's rs1/rs2 (when that read is enabled) or rd[i].
- issue_grant[0] = req_valid[0] & ~hazard[0] & ~stall & ~flush.
- issue_grant[i] = issue_grant[i-1] & req_valid[i] & ~hazard[i]. Grants are strictly in-order; there are no holes.
- Set on a granted slot with rd_we and rd!=0, at the next edge:
  - busy=1;
  - L=0: var=1, cnt=0;
  - L>=1: var=0, cnt=L-1, busy=(L>1).
- Meaning of L: a dependent instruction may be granted no earlier than producer issue cycle + L. L=1 never sets busy; same-cycle dependents are still blocked by the in-window check.
- Fixed countdown: each cycle with busy & ~var, cnt decrements; when cnt==1, busy clears at the next edge.
- Variable release: wb_valid[p] with busy[wb_addr] & var clears busy/var. A release on a non-busy or fixed entry is ignored. Duplicate releases of the same register in one cycle are equivalent to one.
- Set and release of the same register in one cycle: set wins.
- flush: clears all fixed entries. Variable entries persist until their writeback, because the LSU/DIV complete regardless of flush. Grants are 0 during flush.
- stall: grants are 0; countdowns and releases continue.
- Reset mid-operation: all state is cleared; later wb_valid for cleared registers is ignored.

Optional Feature:
- NCPU_SB_PERF_EN defined:
  - adds output perf_sb_stall_cnt (32-bit);
  - increments on every cycle with req_valid[0] & ~stall & ~flush & hazard[0];
  - wraps at 2^32; cleared by rst.
- NCPU_SB_PERF_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants go in ncpu64k_config.vh: `NCPU_REG_AW, `SB_LAT_VAR (=0).
- Sub-module id_sb_entry, one per register: holds busy/var/cnt and the set/release/countdown/flush logic.
- Hazard check and prefix grant stay in the top level; issue_cnt uses the existing clo popcount.

Test Plan:
- Reset, then slot0 add r3 (L=1), slot1 sub r4 reading r5 -> grant=2'b11, cnt=2; sb_busy stays 0.
- Slot0 mul r6 (L=3) at cycle t; slot1 add reading r6 presented every cycle -> slot1 grant blocked in-window at t; granted alone at t+3; sb_busy[6] high during t+1..t+2 only.
- Slot0 load r7 (L=0), then reader of r7 -> blocked indefinitely; wb_valid[1]=1, wb_addr=7 -> reader granted the next cycle.
- Load r8 (L=0) in flight plus mul r9 (L=4) issued; flush next cycle -> busy[9]=0 immediately after; busy[8] remains until wb for r8.
- Same-cycle: wb release of r10 while a new granted load targets r10 -> busy[10]=1, var=1 afterwards.
- Slot0 writes r0; slot1 reads r0 -> both granted; sb_busy[0] never set.
